// File: rtl/qsfp_test_pkg.sv
// Shared definitions for the QSFP loopback test-word checker: FSM encoding and
// the {seq, ~seq} test-word layout.
package qsfp_test_pkg;

  localparam int SEQ_W = 32;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [2*SEQ_W-1:0] test_word(input logic [SEQ_W-1:0] seq);
    return {seq, ~seq};
  endfunction

endpackage

// File: rtl/qsfp_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a same-cycle increment.
module qsfp_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/qsfp_prbs_checker.sv
// Checks a received {seq, ~seq} counting pattern: acquires alignment, declares
// lock after LOCK_WORDS good words, and keeps error/word/loss statistics.
module qsfp_prbs_checker
  import qsfp_test_pkg::*;
#(
  parameter int LOCK_WORDS = 8,
  parameter int LOSS_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rx_data,
  input  logic        rx_valid,
  input  logic        rx_is_lockedtodata,
  input  logic        clear_counters,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_count,
  output logic [47:0] word_count,
  output logic [15:0] loss_count,
  output logic [1:0]  state
);

  localparam int MW = $clog2(LOCK_WORDS + 1);
  localparam int LW = $clog2(LOSS_WORDS + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_WORDS - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_WORDS - 1);

  state_t           st, st_nxt;
  logic [SEQ_W-1:0] expected, exp_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [LW-1:0]    miss_cnt, miss_nxt;
  logic             err_inc, loss_inc, word_inc;

  logic [SEQ_W-1:0] rx_hi, rx_lo;
  logic             fmt_ok, word_ok;

  assign rx_hi   = rx_data[63:32];
  assign rx_lo   = rx_data[31:0];
  assign fmt_ok  = (rx_hi == ~rx_lo);
  assign word_ok = (rx_data == test_word(expected));

  // Stage p0: next-state and counter-strobe decode for the current word
  always_comb begin
    st_nxt    = st;
    exp_nxt   = expected;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_inc   = 1'b0;
    loss_inc  = 1'b0;
    word_inc  = 1'b0;
    if (!rx_is_lockedtodata) begin
      st_nxt    = SEEK;
      match_nxt = '0;
      miss_nxt  = '0;
      loss_inc  = (st == LOCKED);
    end else if (rx_valid) begin
      case (st)
        SEEK: begin
          if (fmt_ok) begin
            exp_nxt   = rx_hi + 1'b1;
            match_nxt = MW'(1);
            st_nxt    = VERIFY;
          end
        end
        VERIFY: begin
          if (word_ok) begin
            exp_nxt   = expected + 1'b1;
            match_nxt = match_cnt + 1'b1;
            if (match_cnt == LOCK_LAST) begin
              st_nxt    = LOCKED;
              match_nxt = '0;
            end
          end else begin
            st_nxt    = SEEK;
            match_nxt = '0;
          end
        end
        LOCKED: begin
          // Expected advances on every word so a single bad word does not desync.
          word_inc = 1'b1;
          exp_nxt  = expected + 1'b1;
          if (word_ok) begin
            miss_nxt = '0;
          end else begin
            err_inc = 1'b1;
            if (miss_cnt == LOSS_LAST) begin
              st_nxt   = SEEK;
              miss_nxt = '0;
              loss_inc = 1'b1;
            end else begin
              miss_nxt = miss_cnt + 1'b1;
            end
          end
        end
        default: st_nxt = SEEK;
      endcase
    end
  end

  // Stage p1: registered FSM, expected value and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= SEEK;
      expected   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      word_count <= '0;
    end else begin
      st        <= st_nxt;
      expected  <= exp_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= (st_nxt == LOCKED);
      err_pulse <= err_inc;
      if (clear_counters) begin
        word_count <= '0;
      end else if (word_inc) begin
        word_count <= word_count + 1'b1;
      end
    end
  end

  qsfp_sat_counter #(.WIDTH(32)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear_counters),
    .count (err_count)
  );

  qsfp_sat_counter #(.WIDTH(16)) u_loss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (loss_inc),
    .clr   (clear_counters),
    .count (loss_count)
  );

  assign state = st;

endmodule

// File: tb/tb_qsfp_prbs_checker.sv
// Directed bench for qsfp_prbs_checker: acquisition, lock, errors, loss,
// sequence wrap, CDR drop, counter clear and reset.
module tb_qsfp_prbs_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_is_lockedtodata;
  logic        clear_counters;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [47:0] word_count;
  logic [15:0] loss_count;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] s;

  qsfp_prbs_checker #(.LOCK_WORDS(8), .LOSS_WORDS(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .rx_is_lockedtodata (rx_is_lockedtodata),
    .clear_counters     (clear_counters),
    .locked             (locked),
    .err_pulse          (err_pulse),
    .err_count          (err_count),
    .word_count         (word_count),
    .loss_count         (loss_count),
    .state              (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read after the next edge.
  task automatic drive(input logic [63:0] d, input logic v);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] seq, input logic [63:0] flip);
    drive({seq, ~seq} ^ flip, 1'b1);
  endtask

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0;
    rx_is_lockedtodata = 1'b1; clear_counters = 1'b0;
    @(posedge clk); #1;
    drive(64'd0, 1'b0);
    chk("rst_state", state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_loss_count", loss_count, 0);
    reset = 1'b0;

    // Clean acquisition from 0x100; lock appears after the 8th word (0x107)
    send(32'h100, 0);
    chk("acq_verify", state, 1);
    for (int i = 1; i < 7; i++) send(32'h100 + i, 0);
    chk("acq_not_yet_locked", locked, 0);
    send(32'h107, 0);
    chk("acq_locked", locked, 1);
    chk("acq_state", state, 2);
    chk("acq_err_count", err_count, 0);
    chk("acq_word_count", word_count, 0);
    for (int i = 8; i < 11; i++) send(32'h100 + i, 0);
    chk("lock_word_count", word_count, 3);

    // Single corrupted word
    s = 32'h10B;
    send(s, 64'h1); s++;
    chk("single_err_pulse", err_pulse, 1);
    chk("single_err_count", err_count, 1);
    chk("single_locked", locked, 1);
    send(s, 0); s++;
    chk("single_pulse_clear", err_pulse, 0);
    chk("single_word_count", word_count, 5);

    // Invalid word holds everything
    drive(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    chk("invalid_word_count", word_count, 5);
    chk("invalid_err_count", err_count, 1);

    // Burst of 4 bad words drops lock
    for (int i = 0; i < 3; i++) begin send(s, 64'h1); s++; end
    chk("burst3_state", state, 2);
    send(s, 64'h1); s++;
    chk("burst4_state", state, 0);
    chk("burst4_locked", locked, 0);
    chk("burst4_loss", loss_count, 1);
    chk("burst4_err_count", err_count, 5);
    chk("burst4_word_count", word_count, 9);

    // Relock on a sequence that then wraps through 0
    s = 32'hFFFF_FFF6;
    for (int i = 0; i < 7; i++) begin send(s, 0); s++; end
    chk("relock_pre", state, 1);
    send(s, 0); s++;
    chk("relock_locked", locked, 1);
    for (int i = 0; i < 4; i++) begin send(s, 0); s++; end
    chk("wrap_seq_next", s, 32'h2);
    chk("wrap_err_count", err_count, 5);
    chk("wrap_state", state, 2);
    chk("wrap_word_count", word_count, 13);

    // One-cycle CDR drop while locked
    rx_is_lockedtodata = 1'b0;
    send(s, 0); s++;
    rx_is_lockedtodata = 1'b1;
    chk("cdr_state", state, 0);
    chk("cdr_loss", loss_count, 2);
    chk("cdr_word_count", word_count, 13);
    for (int i = 0; i < 8; i++) begin send(s, 0); s++; end
    chk("cdr_relock", locked, 1);

    // Clear collides with a mismatch
    clear_counters = 1'b1;
    send(s, 64'h1); s++;
    clear_counters = 1'b0;
    chk("clr_err_count", err_count, 0);
    chk("clr_loss_count", loss_count, 0);
    chk("clr_word_count", word_count, 0);
    chk("clr_state", state, 2);
    send(s, 0); s++;
    chk("clr_after_word_count", word_count, 1);

    // Reset in VERIFY
    rx_is_lockedtodata = 1'b0;
    drive(64'd0, 1'b0);
    rx_is_lockedtodata = 1'b1;
    chk("drop_loss", loss_count, 1);
    send(s, 0); s++;
    send(s, 0); s++;
    chk("pre_rst_verify", state, 1);
    reset = 1'b1;
    send(s, 0); s++;
    reset = 1'b0;
    chk("midrst_state", state, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_loss", loss_count, 0);
    chk("midrst_err_pulse", err_pulse, 0);

    // Mismatch in VERIFY returns to SEEK
    send(32'h50, 0);
    chk("verify_enter", state, 1);
    send(32'h52, 0);
    chk("verify_miss_seek", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
